alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Controller on the issuing end of the 8-bit ALU interface.
- Accepts 8085 arithmetic/logic opcodes, fetches the operand (register read or immediate byte) and drives alu_op/A/B/F into the ALU.
- Captures the ALU result and flags into the accumulator and flag register it owns.
- Sits between instruction fetch/decode and the ALU; the register file is external.

Parameters:
- DATASIZE, 8, operand/result/flag width.
- CARRY_F, 0, flag bit index of CY.
- AUXC_F, 4, flag bit index of AC.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op_valid  input  1  opcode offered.
- op_ready  output  1  sequencer idle, opcode accepted when op_valid & op_ready.
- op_code  input  8  8085 opcode byte.
- imm_valid  input  1  immediate byte offered.
- imm_ready  output  1  sequencer waiting for immediate.
- imm_data  input  8  immediate byte.
- reg_rd  output  1  register-file read strobe.
- reg_sel  output  3  register index (opcode sss field).
- reg_data  input  8  register data, valid the cycle after reg_rd.
- alu_op  output  2  00 add+carry, 01 sub-borrow, 10 AND, 11 compare.
- alu_a  output  8  ALU operand A (accumulator).
- alu_b  output  8  ALU operand B.
- alu_f  output  8  ALU flag input.
- alu_r  input  8  ALU result.
- alu_fo  input  8  ALU flag output (S7 Z6 AC4 P2 CY0; bits 5,3,1 zero).
- acc  output  8  accumulator.
- flags  output  8  flag register.
- done  output  1  one-cycle pulse, writeback complete.
- illegal  output  1  one-cycle pulse, unsupported opcode.

Behaviour:
- Reset (async, any state): state=IDLE; acc=0x00, flags=0x00, alu_op=2'b00, alu_a/b/f=0x00; op_ready=1; imm_ready, reg_rd, done, illegal=0. In-flight op abandoned, no writeback.
- Decode on accept:
  - Register forms 10ggg sss: ADD(000), ADC(001), SUB(010), SBB(011), ANA(100), CMP(111). sss=110 (M) is illegal.
  - Immediate forms: ADI C6, ACI CE, SUI D6, SBI DE, ANI E6, CPI FE.
  - All else illegal, including XRA/ORA/XRI/ORI.
- States: IDLE, RDREG, RDWAIT, IMM, EXEC, DONE, ILL.
- IDLE: op_ready=1. On accept, latch op class and carry-use bit, then go to RDREG (register form), IMM (immediate form) or ILL (illegal).
- RDREG: reg_rd=1, reg_sel=sss for exactly one cycle, then RDWAIT.
- RDWAIT: sample reg_data into operand B at cycle end, then EXEC.
- IMM: imm_ready=1. Stay until imm_valid; on imm_valid & imm_ready sample imm_data into B, then EXEC. Unbounded stall allowed.
- EXEC: drive alu_op, alu_a=acc, alu_b=B, alu_f={flags[7:1], cin}.
  - cin = flags[CARRY_F] for ADC/SBB/ACI/SBI; cin = 0 for all other ops.
  - At cycle end: flags<=alu_fo, then acc<=alu_r except for CMP/CPI, where acc is unchanged.
  - Go to DONE.
- DONE: done=1 for one cycle; acc/flags already updated; go to IDLE.
- ILL: illegal=1 for one cycle; acc/flags/reg_rd untouched; go to IDLE.
- ALU-side outputs are registered and hold their last value outside EXEC.
- Latency from the accept edge:
  - Register form: done asserted 4 cycles later.
  - Immediate form with imm_valid already high: done 3 cycles later.
  - Illegal: illegal asserted 1 cycle later.
- op_ready=0 in every state except IDLE; no pipelining or back-to-back overlap.
- imm_valid outside IMM is ignored.

Test Plan:
- Add masks carry: acc=0x05, flags=0x01, ADD B (0x80), reg B=0x03 -> reg_sel=0, reg_rd one cycle, alu_f[0]=0; done at accept+4; acc=0x08, flags=0x00.
- ACI uses carry: acc=0xFF, flags=0x01, ACI (0xCE) imm 0x00 -> acc=0x00, flags=0x55 (Z,AC,P,CY); done at accept+3.
- Compare leaves acc unchanged: acc=0x05, CPI (0xFE) imm 0x07 -> acc=0x05, flags=0x81 (S,CY).
- Illegal opcodes: 0xA8 and 0x86 -> illegal one-cycle pulse each, no reg_rd, no done, acc/flags unchanged, op_ready high the following cycle.
- Immediate stall: acc=0xF3, flags=0x10, ANI (0xE6) with imm_valid low 5 cycles -> imm_ready high throughout, no done. Then imm 0x0F -> acc=0x03, flags=0x14.
- Reset mid-op: rst_n low while in IMM -> immediately IDLE, acc=0x00, flags=0x00, op_ready=1, no done.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - opcode, operand, register-file and ALU signals of the ALU sequencer
// master is the sequencer's view; slave is the decode/register-file/ALU side.
interface alu_sequencer_if #(
   parameter int DATASIZE = 8
);
   logic                op_valid;
   logic                op_ready;
   logic [7:0]          op_code;
   logic                imm_valid;
   logic                imm_ready;
   logic [DATASIZE-1:0] imm_data;
   logic                reg_rd;
   logic [2:0]          reg_sel;
   logic [DATASIZE-1:0] reg_data;
   logic [1:0]          alu_op;
   logic [DATASIZE-1:0] alu_a;
   logic [DATASIZE-1:0] alu_b;
   logic [DATASIZE-1:0] alu_f;
   logic [DATASIZE-1:0] alu_r;
   logic [DATASIZE-1:0] alu_fo;
   logic [DATASIZE-1:0] acc;
   logic [DATASIZE-1:0] flags;
   logic                done;
   logic                illegal;

   modport master (
      input  op_valid, op_code, imm_valid, imm_data, reg_data, alu_r, alu_fo,
      output op_ready, imm_ready, reg_rd, reg_sel, alu_op, alu_a, alu_b, alu_f,
             acc, flags, done, illegal
   );

   modport slave (
      output op_valid, op_code, imm_valid, imm_data, reg_data, alu_r, alu_fo,
      input  op_ready, imm_ready, reg_rd, reg_sel, alu_op, alu_a, alu_b, alu_f,
             acc, flags, done, illegal
   );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - 8085 arithmetic/logic opcode sequencer driving an external 8-bit ALU
// Fetches operand B from the register file or an immediate byte, then writes the ALU result back.
module alu_sequencer #(
   parameter int DATASIZE = 8,
   parameter int CARRY_F  = 0,
   parameter int AUXC_F   = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   alu_sequencer_if.master bus
);

   if (CARRY_F >= DATASIZE || AUXC_F >= DATASIZE || CARRY_F == AUXC_F) begin : g_flag_idx_check
      $error("alu_sequencer: flag bit indices out of range or overlapping");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_RDREG, S_RDWAIT, S_IMM, S_EXEC, S_DONE, S_ILL
   } state_t;

   state_t              state, state_nx;
   logic [1:0]          op_q, dec_op, alu_op_q;
   logic                cin_q, dec_cin, dec_ok, is_reg, is_imm;
   logic [2:0]          sel_q;
   logic [DATASIZE-1:0] acc_q, flags_q, a_q, b_q, f_q, f_next;

   // The ggg field selects the operation identically for register and immediate forms.
   always_comb begin
      dec_op  = 2'b00;
      dec_cin = 1'b0;
      dec_ok  = 1'b0;
      case (bus.op_code[5:3])
         3'b000: begin dec_op = 2'b00; dec_ok = 1'b1; end
         3'b001: begin dec_op = 2'b00; dec_ok = 1'b1; dec_cin = 1'b1; end
         3'b010: begin dec_op = 2'b01; dec_ok = 1'b1; end
         3'b011: begin dec_op = 2'b01; dec_ok = 1'b1; dec_cin = 1'b1; end
         3'b100: begin dec_op = 2'b10; dec_ok = 1'b1; end
         3'b111: begin dec_op = 2'b11; dec_ok = 1'b1; end
         default: ;
      endcase
   end

   assign is_reg = dec_ok && (bus.op_code[7:6] == 2'b10) && (bus.op_code[2:0] != 3'b110);
   assign is_imm = dec_ok && (bus.op_code[7:6] == 2'b11) && (bus.op_code[2:0] == 3'b110);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx      = state;
      bus.op_ready  = 1'b0;
      bus.imm_ready = 1'b0;
      bus.reg_rd    = 1'b0;
      bus.done      = 1'b0;
      bus.illegal   = 1'b0;
      case (state)
         S_IDLE: begin
            bus.op_ready = 1'b1;
            if (bus.op_valid) state_nx = is_reg ? S_RDREG : (is_imm ? S_IMM : S_ILL);
         end
         S_RDREG: begin
            bus.reg_rd = 1'b1;
            state_nx   = S_RDWAIT;
         end
         S_RDWAIT: state_nx = S_EXEC;
         S_IMM: begin
            bus.imm_ready = 1'b1;
            if (bus.imm_valid) state_nx = S_EXEC;
         end
         S_EXEC: state_nx = S_DONE;
         S_DONE: begin
            bus.done = 1'b1;
            state_nx = S_IDLE;
         end
         S_ILL: begin
            bus.illegal = 1'b1;
            state_nx    = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Only ADC/SBB/ACI/SBI see the stored carry; every other op gets a cleared carry-in.
   always_comb begin
      f_next          = flags_q;
      f_next[CARRY_F] = cin_q & flags_q[CARRY_F];
   end

   // ALU operands are loaded on entry to EXEC so they are stable for the whole EXEC cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= 2'b00;
         cin_q    <= 1'b0;
         sel_q    <= 3'b000;
         alu_op_q <= 2'b00;
         a_q      <= '0;
         b_q      <= '0;
         f_q      <= '0;
         acc_q    <= '0;
         flags_q  <= '0;
      end else begin
         if (state == S_IDLE && bus.op_valid) begin
            op_q  <= dec_op;
            cin_q <= dec_cin;
            sel_q <= bus.op_code[2:0];
         end
         if (state == S_RDWAIT || (state == S_IMM && bus.imm_valid)) begin
            alu_op_q <= op_q;
            a_q      <= acc_q;
            f_q      <= f_next;
            b_q      <= (state == S_RDWAIT) ? bus.reg_data : bus.imm_data;
         end
         if (state == S_EXEC) begin
            flags_q <= bus.alu_fo;
            if (op_q != 2'b11) acc_q <= bus.alu_r;
         end
      end
   end

   assign bus.reg_sel = sel_q;
   assign bus.alu_op  = alu_op_q;
   assign bus.alu_a   = a_q;
   assign bus.alu_b   = b_q;
   assign bus.alu_f   = f_q;
   assign bus.acc     = acc_q;
   assign bus.flags   = flags_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized self-checking bench for alu_sequencer with an opcode-level model
`timescale 1ns/1ps
module tb_alu_sequencer;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   alu_sequencer_if bus ();

   alu_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   logic chk_en   = 1'b0;
   logic [7:0] regfile [8];

   // Expected timeline of the op in flight, in absolute cycle numbers.
   int busy_from = 1, busy_to = 0, done_at = -1, ill_at = -1, rd_at = -1;
   int imm_from = 1, imm_to = 0, exec_at = -1, upd_at = 1 << 30;
   logic [7:0] m_acc = 8'h00, m_flags = 8'h00;
   logic [7:0] prev_acc = 8'h00, prev_flags = 8'h00, nxt_acc = 8'h00, nxt_flags = 8'h00;
   logic [7:0] exp_b = 8'h00, exp_f = 8'h00;
   logic [1:0] exp_op = 2'b00;
   logic [2:0] exp_sel = 3'd0;

   function automatic logic [15:0] alu_calc(input logic [1:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic cin);
      logic [8:0] s;
      logic [4:0] h;
      logic [7:0] r;
      logic       cy, ac;
      s = '0; h = '0;
      case (op)
         2'b00: begin
            s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            h = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, cin};
            r = s[7:0]; cy = s[8]; ac = h[4];
         end
         2'b10: begin
            r = a & b; cy = 1'b0; ac = a[3] | b[3];
         end
         default: begin
            s = {1'b0, a} - {1'b0, b} - {8'd0, cin};
            h = {1'b0, a[3:0]} + {1'b0, ~b[3:0]} + {4'd0, ~cin};
            r = s[7:0]; cy = s[8]; ac = h[4];
         end
      endcase
      return {r, r[7], (r == 8'd0), 1'b0, ac, 1'b0, ~^r, 1'b0, cy};
   endfunction

   // kind: 0 illegal, 1 register form, 2 immediate form
   function automatic void model_decode(input logic [7:0] opc, output int kind,
                                        output logic [1:0] op, output logic uc);
      kind = 0; op = 2'b00; uc = 1'b0;
      case (opc)
         8'hC6: begin kind = 2; op = 2'b00; end
         8'hCE: begin kind = 2; op = 2'b00; uc = 1'b1; end
         8'hD6: begin kind = 2; op = 2'b01; end
         8'hDE: begin kind = 2; op = 2'b01; uc = 1'b1; end
         8'hE6: begin kind = 2; op = 2'b10; end
         8'hFE: begin kind = 2; op = 2'b11; end
         default: begin
            if (opc >= 8'h80 && opc <= 8'hBF && opc[2:0] != 3'd6) begin
               case (opc[5:3])
                  3'd0: begin kind = 1; op = 2'b00; end
                  3'd1: begin kind = 1; op = 2'b00; uc = 1'b1; end
                  3'd2: begin kind = 1; op = 2'b01; end
                  3'd3: begin kind = 1; op = 2'b01; uc = 1'b1; end
                  3'd4: begin kind = 1; op = 2'b10; end
                  3'd7: begin kind = 1; op = 2'b11; end
                  default: kind = 0;
               endcase
            end
         end
      endcase
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always_comb begin
      {bus.alu_r, bus.alu_fo} = alu_calc(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_f[0]);
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      bus.reg_data <= bus.reg_rd ? regfile[bus.reg_sel] : 8'($urandom);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("op_ready", bus.op_ready, !(cyc >= busy_from && cyc <= busy_to));
         check("done", bus.done, cyc == done_at);
         check("illegal", bus.illegal, cyc == ill_at);
         check("reg_rd", bus.reg_rd, cyc == rd_at);
         if (cyc == rd_at) check("reg_sel", bus.reg_sel, exp_sel);
         check("imm_ready", bus.imm_ready, cyc >= imm_from && cyc <= imm_to);
         check("acc", bus.acc, (cyc >= upd_at) ? nxt_acc : prev_acc);
         check("flags", bus.flags, (cyc >= upd_at) ? nxt_flags : prev_flags);
         if (cyc == exec_at) begin
            check("alu_op", bus.alu_op, exp_op);
            check("alu_a", bus.alu_a, prev_acc);
            check("alu_b", bus.alu_b, exp_b);
            check("alu_f", bus.alu_f, exp_f);
         end
      end
   end

   task automatic run_op(input logic [7:0] opc, input logic [7:0] imm, input int stall, output int lat);
      int         kind, k;
      logic [1:0] op;
      logic       uc, cin;
      logic [7:0] opnd;
      logic [15:0] res;
      model_decode(opc, kind, op, uc);
      @(negedge clk);
      k = cyc;
      prev_acc = m_acc; prev_flags = m_flags; nxt_acc = m_acc; nxt_flags = m_flags;
      cin = uc & m_flags[0];
      busy_from = k + 1; rd_at = -1; imm_from = 1; imm_to = 0;
      done_at = -1; ill_at = -1; exec_at = -1; upd_at = 1 << 30;
      if (kind == 0) begin
         ill_at  = k + 1;
         busy_to = k + 1;
      end else begin
         if (kind == 1) begin
            opnd = regfile[opc[2:0]];
            rd_at = k + 1; exp_sel = opc[2:0];
            done_at = k + 4;
         end else begin
            opnd = imm;
            imm_from = k + 1; imm_to = k + 1 + stall;
            done_at = k + 3 + stall;
         end
         exec_at = done_at - 1; busy_to = done_at; upd_at = done_at;
         res = alu_calc(op, m_acc, opnd, cin);
         nxt_flags = res[7:0];
         nxt_acc   = (op == 2'b11) ? m_acc : res[15:8];
         exp_op = op; exp_b = opnd; exp_f = {m_flags[7:1], cin};
      end
      bus.op_valid = 1'b1;
      bus.op_code  = opc;
      if (kind == 2) begin
         bus.imm_valid = (stall == 0);
         bus.imm_data  = (stall == 0) ? imm : 8'($urandom);
      end else begin
         bus.imm_valid = 1'($urandom_range(0, 1));
         bus.imm_data  = 8'($urandom);
      end
      @(negedge clk);
      bus.op_valid = 1'b0;
      bus.op_code  = 8'($urandom);
      if (kind == 2) begin
         for (int i = 0; i < stall; i++) begin
            bus.imm_valid = 1'b0;
            @(negedge clk);
         end
         bus.imm_valid = 1'b1;
         bus.imm_data  = imm;
      end
      lat = -1;
      for (int i = 0; i < 40; i++) begin
         if (bus.done || bus.illegal) begin
            lat = cyc - k;
            break;
         end
         @(negedge clk);
      end
      bus.imm_valid = 1'b0;
      if (lat < 0) begin
         n_checks++; n_fail++;
         $display("FAIL op_complete: no done/illegal within 40 cycles for opcode 0x%02h", opc);
      end
      m_acc = nxt_acc; m_flags = nxt_flags;
   endtask

   initial begin
      int lat, r;
      logic [2:0] g, sss;
      logic [7:0] opc;
      logic [2:0] glist [6];
      glist = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
      bus.op_valid = 1'b0; bus.op_code = 8'h00; bus.imm_valid = 1'b0; bus.imm_data = 8'h00;
      for (int i = 0; i < 8; i++) regfile[i] = 8'($urandom);

      #1 rst_n = 1'b0;
      #2;
      check("rst_op_ready", bus.op_ready, 1'b1);
      check("rst_acc", bus.acc, 8'h00);
      check("rst_flags", bus.flags, 8'h00);
      check("rst_alu_a", bus.alu_a, 8'h00);
      check("rst_ctl", {bus.imm_ready, bus.reg_rd, bus.done, bus.illegal, bus.alu_op}, 6'd0);
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      run_op(8'hC6, 8'hFF, 0, lat);
      run_op(8'hC6, 8'h06, 0, lat);
      check("setup_acc", bus.acc, 8'h05);
      check("setup_flags", bus.flags, 8'h15);

      regfile[0] = 8'h03;
      run_op(8'h80, 8'h00, 0, lat);
      check("add_lat", lat, 4);
      check("add_acc", bus.acc, 8'h08);
      check("add_flags", bus.flags, 8'h00);

      run_op(8'hD6, 8'h09, 0, lat);
      check("sui_acc", bus.acc, 8'hFF);
      check("sui_flags", bus.flags, 8'h85);
      run_op(8'hCE, 8'h00, 0, lat);
      check("aci_lat", lat, 3);
      check("aci_acc", bus.acc, 8'h00);
      check("aci_flags", bus.flags, 8'h55);

      run_op(8'hC6, 8'h05, 0, lat);
      run_op(8'hFE, 8'h07, 0, lat);
      check("cpi_acc", bus.acc, 8'h05);
      check("cpi_flags", bus.flags, 8'h81);

      run_op(8'hA8, 8'h00, 0, lat);
      check("xra_lat", lat, 1);
      run_op(8'h86, 8'h00, 0, lat);
      check("addm_lat", lat, 1);
      check("ill_acc", bus.acc, 8'h05);
      check("ill_flags", bus.flags, 8'h81);

      run_op(8'hC6, 8'hEE, 0, lat);
      run_op(8'hE6, 8'h0F, 5, lat);
      check("ani_lat", lat, 8);
      check("ani_acc", bus.acc, 8'h03);
      check("ani_flags", bus.flags, 8'h14);

      for (int n = 0; n < 150; n++) begin
         regfile[$urandom_range(0, 7)] = 8'($urandom);
         r = $urandom_range(0, 99);
         g = glist[$urandom_range(0, 5)];
         if (r < 55) begin
            sss = 3'($urandom_range(0, 6));
            if (sss == 3'd6) sss = 3'd7;
            opc = {2'b10, g, sss};
         end else if (r < 85) begin
            opc = {2'b11, g, 3'b110};
         end else begin
            opc = 8'($urandom);
         end
         run_op(opc, 8'($urandom), $urandom_range(0, 3), lat);
      end

      run_op(8'hC6, 8'h5A, 0, lat);
      @(negedge clk);
      chk_en = 1'b0;
      bus.op_valid = 1'b1; bus.op_code = 8'hE6; bus.imm_valid = 1'b0;
      @(negedge clk);
      bus.op_valid = 1'b0;
      check("midrst_in_imm", bus.imm_ready, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_op_ready", bus.op_ready, 1'b1);
      check("midrst_acc", bus.acc, 8'h00);
      check("midrst_flags", bus.flags, 8'h00);
      check("midrst_ctl", {bus.imm_ready, bus.done, bus.illegal}, 3'd0);
      @(negedge clk);
      rst_n = 1'b1;
      m_acc = 8'h00; m_flags = 8'h00; prev_acc = 8'h00; prev_flags = 8'h00;
      nxt_acc = 8'h00; nxt_flags = 8'h00; upd_at = 1 << 30;
      busy_from = 1; busy_to = 0; done_at = -1; ill_at = -1; rd_at = -1;
      imm_from = 1; imm_to = 0; exec_at = -1;
      chk_en = 1'b1;
      bus.imm_valid = 1'b1; bus.imm_data = 8'h77;
      repeat (4) @(negedge clk);
      bus.imm_valid = 1'b0;
      run_op(8'hC6, 8'h12, 0, lat);
      check("post_rst_acc", bus.acc, 8'h12);

      @(negedge clk);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
